multi_channel_clock_divider: RTL

- NUM_CH independent flip-flop clock dividers on one input clock, each with a runtime-programmable half-period, a glitch-free enable and a shared phase-alignment strobe.
- Successor to the fixed single-output divider.
- Feeds the NCO sample-rate and DAC-update strobes.
- Divisor changes never produce a runt pulse: new values apply only at a toggle boundary.

---
 rtl/multi_channel_clock_divider.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multi_channel_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_clock_divider
// Purpose  : NUM_CH independent flip-flop clock dividers running from clk_in.
//            Each channel has a runtime-programmable half-period, a glitch-free
//            run enable and responds to a shared phase-alignment strobe.
//            New half-periods take effect only at a toggle boundary (or
//            immediately on an idle channel), so no runt pulse is produced.
// Ports    : clk_in     - input clock, all logic on its rising edge
//            rst_n      - asynchronous active-low reset
//            en         - per-channel run enable
//            sync       - one-cycle phase-alignment strobe (all channels)
//            cfg_valid  - config write request
//            cfg_ready  - config write accepted when valid & ready
//            cfg_ch     - target channel of the config write
//            cfg_half   - new half-period in clk_in cycles
//            cfg_err    - one-cycle pulse: write rejected (half == 0)
//            clk_out    - divided clocks (registered)
//            rise_tick  - one-cycle pulse with each 0->1 edge of clk_out
//            pending    - shadow half-period waiting to be applied
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module multi_channel_clock_divider #(
  parameter int NUM_CH       = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int DEFAULT_HALF = 25,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    en,
  input  logic                 sync,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [CNT_WIDTH-1:0] cfg_half,
  output logic                 cfg_err,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    rise_tick,
  output logic [NUM_CH-1:0]    pending
);

  localparam int                   c_ch_span      = 1 << CH_W;
  localparam logic [CNT_WIDTH-1:0] c_one          = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_default_half = CNT_WIDTH'(DEFAULT_HALF);

  // pending widened to the full index range so cfg_ch can never index out of
  // bounds when NUM_CH is not a power of two.
  logic [c_ch_span-1:0] w_pend_pad;
  logic                 w_ch_ok;
  logic                 w_accept;
  logic                 w_zero_half;
  logic                 r_err;

  always_comb begin
    w_pend_pad             = '0;
    w_pend_pad[NUM_CH-1:0] = pending;
  end

  assign w_ch_ok     = (32'(cfg_ch) < 32'(NUM_CH));
  // A channel with a value already queued refuses further writes until the
  // queued value has been applied.
  assign cfg_ready   = rst_n & w_ch_ok & ~w_pend_pad[cfg_ch];
  assign w_accept    = cfg_valid & cfg_ready;
  assign w_zero_half = (cfg_half == '0);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & w_zero_half;
    end
  end

  assign cfg_err = r_err;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_WIDTH-1:0] r_cnt;
      logic [CNT_WIDTH-1:0] r_half;
      logic [CNT_WIDTH-1:0] r_shadow;
      logic                 r_clk;
      logic                 r_rise;
      logic                 r_pend;
      logic                 w_wr;
      logic                 w_run;
      logic                 w_tc;

      assign w_wr  = w_accept & ~w_zero_half & (cfg_ch == CH_W'(i));
      // A disabled channel keeps counting while high so that the high phase
      // is never cut short; it stops once it has toggled back to 0.
      assign w_run = en[i] | r_clk;
      assign w_tc  = (r_cnt == (r_half - c_one));

      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt    <= '0;
          r_half   <= c_default_half;
          r_shadow <= '0;
          r_clk    <= 1'b0;
          r_rise   <= 1'b0;
          r_pend   <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          if (sync && w_run) begin
            // Phase alignment. A draining (disabled) channel is forced low
            // here; its queued value is applied on the following idle cycle.
            r_cnt <= '0;
            r_clk <= 1'b0;
            if (en[i] && r_pend) begin
              r_half <= r_shadow;
              r_pend <= 1'b0;
            end
            // A write landing with sync is queued, not applied by this sync.
            if (w_wr) begin
              r_shadow <= cfg_half;
              r_pend   <= 1'b1;
            end
          end else if (!w_run) begin
            // Idle: counter parked at 0, queued or direct writes apply now.
            r_cnt <= '0;
            if (r_pend) begin
              r_half <= r_shadow;
              r_pend <= 1'b0;
            end else if (w_wr) begin
              r_half <= cfg_half;
            end
          end else begin
            if (w_tc) begin
              // The toggle itself uses the old half; the new one governs
              // the phase that starts here.
              r_cnt  <= '0;
              r_clk  <= ~r_clk;
              r_rise <= ~r_clk;
              if (r_pend) begin
                r_half <= r_shadow;
                r_pend <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + c_one;
            end
            if (w_wr) begin
              r_shadow <= cfg_half;
              r_pend   <= 1'b1;
            end
          end
        end
      end

      assign clk_out[i]   = r_clk;
      assign rise_tick[i] = r_rise;
      assign pending[i]   = r_pend;
    end
  endgenerate

endmodule
`default_nettype wire
